// File: rtl/bsg_plic_src_cond.sv
// Interrupt-source conditioning ahead of the PLIC: per-source synchronizer,
// polarity normalization to active-high, debounce filter and enable gating.
module bsg_plic_src_cond #(
  parameter int unsigned          num_src_p         = 2,
  parameter int unsigned          sync_stages_p     = 2,
  parameter int unsigned          debounce_cycles_p = 4,
  parameter logic [num_src_p-1:0] invert_mask_p     = '0
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [num_src_p-1:0] intr_raw_i,
  input  logic [num_src_p-1:0] en_i,
  output logic [num_src_p-1:0] intr_src_o,
  output logic [num_src_p-1:0] rise_o
);

  localparam int unsigned          cnt_w_lp   = $clog2(debounce_cycles_p + 1);
  localparam logic [cnt_w_lp-1:0] cnt_max_lp = cnt_w_lp'(debounce_cycles_p - 1);

  for (genvar i = 0; i < num_src_p; i++) begin : g_src
    logic [sync_stages_p-1:0] sync_q, sync_d;
    logic [cnt_w_lp-1:0]      cnt_q, cnt_d;
    logic                     q_q, q_d;
    logic                     rise_q, rise_d;
    logic                     norm;

    // Only the last synchronizer stage feeds the filter; stage 0 may go metastable.
    assign sync_d = {sync_q[sync_stages_p-2:0], intr_raw_i[i]};
    assign norm   = sync_q[sync_stages_p-1] ^ invert_mask_p[i];

    always_comb begin
      q_d   = q_q;
      cnt_d = '0;
      if (!en_i[i]) begin
        q_d   = 1'b0;
        cnt_d = '0;
      end else if (norm != q_q) begin
        if (cnt_q == cnt_max_lp) begin
          q_d = norm;
        end else begin
          cnt_d = cnt_q + cnt_w_lp'(1);
        end
      end
      rise_d = q_d & ~q_q;
    end

    // Synchronizer resets to the inactive raw level so the normalized value starts at 0.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        sync_q <= {sync_stages_p{invert_mask_p[i]}};
        cnt_q  <= '0;
        q_q    <= 1'b0;
        rise_q <= 1'b0;
      end else begin
        sync_q <= sync_d;
        cnt_q  <= cnt_d;
        q_q    <= q_d;
        rise_q <= rise_d;
      end
    end

    assign intr_src_o[i] = q_q;
    assign rise_o[i]     = rise_q;
  end

endmodule

// File: tb/tb_bsg_plic_src_cond.sv
// Bench for bsg_plic_src_cond: default-polarity instance (a) and an instance
// with source 1 active-low (b), both checked against a run-length reference model.
module tb_bsg_plic_src_cond;

  localparam int unsigned S = 2;
  localparam int unsigned D = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] raw_a = 2'b00, en_a = 2'b11, src_a, rise_a;
  logic [1:0] raw_b = 2'b10, en_b = 2'b11, src_b, rise_b;

  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  bsg_plic_src_cond #(
    .num_src_p(2), .sync_stages_p(S), .debounce_cycles_p(D), .invert_mask_p(2'b00)
  ) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .intr_raw_i(raw_a), .en_i(en_a),
    .intr_src_o(src_a), .rise_o(rise_a)
  );

  bsg_plic_src_cond #(
    .num_src_p(2), .sync_stages_p(S), .debounce_cycles_p(D), .invert_mask_p(2'b10)
  ) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .intr_raw_i(raw_b), .en_i(en_b),
    .intr_src_o(src_b), .rise_o(rise_b)
  );

  // Reference model: channels 0,1 = dut_a sources, 2,3 = dut_b sources.
  // hist holds the last S raw samples; its front is what the filter sees.
  bit m_q[4];
  bit m_rise[4];
  int m_run[4];
  bit hist[4][$];

  function automatic bit inv(int ch);
    return (ch == 3);
  endfunction

  function automatic void model_reset();
    for (int ch = 0; ch < 4; ch++) begin
      m_q[ch] = 1'b0; m_rise[ch] = 1'b0; m_run[ch] = 0;
      hist[ch].delete();
      for (int k = 0; k < S; k++) hist[ch].push_back(inv(ch));
    end
  endfunction

  function automatic void model_edge();
    bit raw, en, n, old;
    for (int ch = 0; ch < 4; ch++) begin
      raw = (ch < 2) ? raw_a[ch] : raw_b[ch-2];
      en  = (ch < 2) ? en_a[ch]  : en_b[ch-2];
      n   = hist[ch].pop_front() ^ inv(ch);
      hist[ch].push_back(raw);
      old = m_q[ch];
      if (!en) begin
        m_q[ch] = 1'b0; m_run[ch] = 0;
      end else if (n != m_q[ch]) begin
        m_run[ch]++;
        if (m_run[ch] == D) begin m_q[ch] = n; m_run[ch] = 0; end
      end else begin
        m_run[ch] = 0;
      end
      m_rise[ch] = m_q[ch] & ~old;
    end
  endfunction

  function automatic logic [7:0] model_word();
    return {m_rise[3], m_rise[2], m_q[3], m_q[2], m_rise[1], m_rise[0], m_q[1], m_q[0]};
  endfunction

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk);
      if (rst_n) model_edge();
      #1;
    end
  endtask

  task automatic test_reset();
    model_reset();
    #2;
    checks++;
    if ({rise_b, src_b, rise_a, src_a} !== 8'h00) begin
      errors++; $display("FAIL reset_async got=%h exp=00", {rise_b, src_b, rise_a, src_a});
    end
    tick(2);
    rst_n = 1'b1;
    checks++;
    if ({rise_b, src_b, rise_a, src_a} !== model_word()) begin
      errors++; $display("FAIL reset_release got=%h exp=%h", {rise_b, src_b, rise_a, src_a}, model_word());
    end
  endtask

  task automatic test_latency();
    raw_a[0] = 1'b1;
    for (int e = 0; e < 8; e++) begin
      tick();
      checks++;
      if (src_a[0] !== (e >= 5) || rise_a[0] !== (e == 5)) begin
        errors++; $display("FAIL latency_rise edge=%0d src=%b rise=%b exp_src=%b exp_rise=%b",
                           e, src_a[0], rise_a[0], (e >= 5), (e == 5));
      end
    end
    raw_a[0] = 1'b0;
    for (int e = 0; e < 8; e++) begin
      tick();
      checks++;
      if (src_a[0] !== (e < 5) || rise_a[0] !== 1'b0) begin
        errors++; $display("FAIL latency_fall edge=%0d src=%b rise=%b exp_src=%b exp_rise=0",
                           e, src_a[0], rise_a[0], (e < 5));
      end
    end
  endtask

  task automatic test_glitch();
    raw_a[1] = 1'b1; tick(3); raw_a[1] = 1'b0;
    for (int e = 0; e < 10; e++) begin
      tick();
      checks++;
      if (src_a[1] !== 1'b0) begin
        errors++; $display("FAIL glitch3 edge=%0d src=%b exp=0", e, src_a[1]);
      end
    end
    raw_a[1] = 1'b1;
    for (int e = 0; e < 14; e++) begin
      tick();
      if (e == 3) raw_a[1] = 1'b0;
      checks++;
      if (src_a[1] !== (e >= 5 && e <= 8) || rise_a[1] !== (e == 5)) begin
        errors++; $display("FAIL pulse4 edge=%0d src=%b rise=%b exp_src=%b",
                           e, src_a[1], rise_a[1], (e >= 5 && e <= 8));
      end
    end
  endtask

  task automatic test_chatter();
    for (int r = 0; r < 6; r++) begin
      for (int e = 0; e < 4; e++) begin
        raw_a[0] = (e < 3);
        tick();
        checks++;
        if (src_a[0] !== 1'b0) begin
          errors++; $display("FAIL chatter r=%0d e=%0d src=%b exp=0", r, e, src_a[0]);
        end
      end
    end
    raw_a[0] = 1'b1;
    for (int e = 0; e < 7; e++) begin
      tick();
      checks++;
      if (src_a[0] !== (e >= 5)) begin
        errors++; $display("FAIL chatter_hold edge=%0d src=%b exp=%b", e, src_a[0], (e >= 5));
      end
    end
    raw_a[0] = 1'b0; tick(8);
  endtask

  task automatic test_invert();
    checks++;
    if (src_b[1] !== 1'b0) begin
      errors++; $display("FAIL invert_idle src=%b exp=0", src_b[1]);
    end
    raw_b[1] = 1'b0;
    for (int e = 0; e < 7; e++) begin
      tick();
      checks++;
      if (src_b[1] !== (e >= 5) || rise_b[1] !== (e == 5)) begin
        errors++; $display("FAIL invert_assert edge=%0d src=%b rise=%b exp_src=%b",
                           e, src_b[1], rise_b[1], (e >= 5));
      end
    end
    raw_b[1] = 1'b1; tick(8);
  endtask

  task automatic test_enable();
    raw_a[0] = 1'b1; tick(7);
    checks++;
    if (src_a[0] !== 1'b1) begin
      errors++; $display("FAIL enable_pre src=%b exp=1", src_a[0]);
    end
    en_a[0] = 1'b0; tick();
    checks++;
    if (src_a[0] !== 1'b0 || rise_a[0] !== 1'b0) begin
      errors++; $display("FAIL enable_drop src=%b rise=%b exp=0/0", src_a[0], rise_a[0]);
    end
    tick(2);
    en_a[0] = 1'b1;
    for (int e = 0; e < 6; e++) begin
      tick();
      checks++;
      if (src_a[0] !== (e >= 3) || rise_a[0] !== (e == 3)) begin
        errors++; $display("FAIL enable_restore edge=%0d src=%b rise=%b exp_src=%b",
                           e, src_a[0], rise_a[0], (e >= 3));
      end
    end
    raw_a[0] = 1'b0; tick(8);
  endtask

  task automatic test_async_reset();
    raw_a[1] = 1'b1; tick(7);
    raw_a[0] = 1'b1; tick(4);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({rise_b, src_b, rise_a, src_a} !== 8'h00) begin
      errors++; $display("FAIL async_reset got=%h exp=00", {rise_b, src_b, rise_a, src_a});
    end
    tick(2);
    rst_n = 1'b1;
    for (int e = 0; e < 7; e++) begin
      tick();
      checks++;
      if (src_a !== ((e >= 5) ? 2'b11 : 2'b00)) begin
        errors++; $display("FAIL reset_relatency edge=%0d src=%b exp=%b", e, src_a,
                           (e >= 5) ? 2'b11 : 2'b00);
      end
    end
    raw_a = 2'b00; tick(8);
  endtask

  task automatic test_random();
    int hold[4];
    for (int ch = 0; ch < 4; ch++) hold[ch] = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int ch = 0; ch < 4; ch++) begin
        if (hold[ch] == 0) begin
          hold[ch] = $urandom_range(1, 9);
          if (ch < 2) raw_a[ch] = ~raw_a[ch]; else raw_b[ch-2] = ~raw_b[ch-2];
        end
        hold[ch]--;
      end
      en_a = {($urandom_range(0, 19) != 0), ($urandom_range(0, 19) != 0)};
      en_b = {($urandom_range(0, 19) != 0), ($urandom_range(0, 19) != 0)};
      tick();
      checks++;
      if ({rise_b, src_b, rise_a, src_a} !== model_word()) begin
        errors++; $display("FAIL random cyc=%0d got=%h exp=%h", cyc,
                           {rise_b, src_b, rise_a, src_a}, model_word());
      end
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_glitch();
    test_chatter();
    test_invert();
    test_enable();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
